// File: rtl/seq_pkg.sv
// Shared definitions for the memory access sequencer: the state encoding
// and the default acknowledge timeout.
package seq_pkg;

    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_F_ADDR = 3'd1,
        S_F_WAIT = 3'd2,
        S_F_LOAD = 3'd3,
        S_D_ADDR = 3'd4,
        S_D_WAIT = 3'd5,
        S_D_DONE = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_F_WAIT) || (s == S_D_WAIT);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts memory wait cycles and flags the last cycle allowed before a timeout.
// TIMEOUT = 0 disables the expiry flag entirely.
module wait_timer #(
    parameter int TIMEOUT = seq_pkg::DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT > 0) && (cnt == LAST);

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences instruction fetches and data accesses onto a single memory port,
// arbitrating round-robin between the two requesters with an ack timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no access in progress, arbitrate fetch_req / data_req
// S_F_ADDR | load MAR from PC
// S_F_WAIT | fetch read on the bus, MDR loads on ack
// S_F_LOAD | load IR, advance PC, pulse fetch_done
// S_D_ADDR | load MAR with data address (and MDR with store data on write)
// S_D_WAIT | data access on the bus, MDR loads on read ack
// S_D_DONE | pulse data_done
// S_ERR    | ack timeout, one cycle, no done pulse
module mem_access_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fetch_req,
    input  logic data_req,
    input  logic data_we,
    input  logic mem_ack,
    input  logic err_clr,
    output logic mem_req,
    output logic mem_we,
    output logic ld_mar,
    output logic ld_mdr,
    output logic ld_ir,
    output logic ld_pc,
    output logic mar_sel,
    output logic mdr_sel,
    output logic fetch_done,
    output logic data_done,
    output logic busy,
    output logic timeout_err
);

    state_t state, state_nxt;
    logic   we_q;
    logic   last_fetch;
    logic   in_wait;
    logic   tmr_clr;
    logic   tmr_en;
    logic   tmr_expired;
    logic   timeout_hit;

    assign in_wait     = is_wait_state(state);
    assign tmr_clr     = (state == S_F_ADDR) || (state == S_D_ADDR);
    assign tmr_en      = in_wait && !mem_ack;
    // An ack arriving on the final allowed cycle still completes normally.
    assign timeout_hit = in_wait && !mem_ack && tmr_expired;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fetch_req && data_req) begin
                    state_nxt = last_fetch ? S_D_ADDR : S_F_ADDR;
                end else if (fetch_req) begin
                    state_nxt = S_F_ADDR;
                end else if (data_req) begin
                    state_nxt = S_D_ADDR;
                end
            end
            S_F_ADDR: state_nxt = S_F_WAIT;
            S_F_WAIT: begin
                if (mem_ack) begin
                    state_nxt = S_F_LOAD;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_F_LOAD: state_nxt = S_IDLE;
            S_D_ADDR: state_nxt = S_D_WAIT;
            S_D_WAIT: begin
                if (mem_ack) begin
                    state_nxt = S_D_DONE;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_D_DONE: state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            last_fetch  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && state_nxt == S_F_ADDR) begin
                last_fetch <= 1'b1;
            end else if (state == S_IDLE && state_nxt == S_D_ADDR) begin
                last_fetch <= 1'b0;
                we_q       <= data_we;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ld_mar     = 1'b0;
        ld_mdr     = 1'b0;
        ld_ir      = 1'b0;
        ld_pc      = 1'b0;
        mar_sel    = 1'b0;
        mdr_sel    = 1'b0;
        fetch_done = 1'b0;
        data_done  = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_F_ADDR: ld_mar = 1'b1;
            S_F_WAIT: begin
                mem_req = 1'b1;
                ld_mdr  = mem_ack;
            end
            S_F_LOAD: begin
                ld_ir      = 1'b1;
                ld_pc      = 1'b1;
                fetch_done = 1'b1;
            end
            S_D_ADDR: begin
                ld_mar  = 1'b1;
                mar_sel = 1'b1;
                ld_mdr  = we_q;
                mdr_sel = we_q;
            end
            S_D_WAIT: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                ld_mdr  = mem_ack && !we_q;
            end
            S_D_DONE: data_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer with TIMEOUT = 4: directed
// sequences push expected transactions, a monitor checks them as they complete.
module tb_mem_access_sequencer;

    localparam int K_FETCH = 0;
    localparam int K_DATA  = 1;
    localparam int K_ERR   = 2;

    // outs bit order: mem_req mem_we ld_mar ld_mdr ld_ir ld_pc mar_sel mdr_sel fetch_done data_done busy timeout_err
    localparam logic [11:0] O_IDLE      = 12'b0000_0000_0000;
    localparam logic [11:0] O_IDLE_ERR  = 12'b0000_0000_0001;
    localparam logic [11:0] O_F_ADDR    = 12'b0010_0000_0010;
    localparam logic [11:0] O_F_WAIT    = 12'b1000_0000_0010;
    localparam logic [11:0] O_F_WAIT_AK = 12'b1001_0000_0010;
    localparam logic [11:0] O_F_LOAD    = 12'b0000_1100_1010;
    localparam logic [11:0] O_D_ADDR_W  = 12'b0011_0011_0010;
    localparam logic [11:0] O_D_ADDR_R  = 12'b0010_0010_0010;
    localparam logic [11:0] O_D_WAIT_W  = 12'b1100_0000_0010;
    localparam logic [11:0] O_D_WAIT_R  = 12'b1000_0000_0010;
    localparam logic [11:0] O_D_WAIT_RA = 12'b1001_0000_0010;
    localparam logic [11:0] O_D_DONE    = 12'b0000_0000_0110;
    localparam logic [11:0] O_ERR       = 12'b0000_0000_0011;

    typedef struct {
        int   kind;
        int   req_cycles;
        logic we;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic fetch_req, data_req, data_we, mem_ack, err_clr;
    logic mem_req, mem_we, ld_mar, ld_mdr, ld_ir, ld_pc, mar_sel, mdr_sel;
    logic fetch_done, data_done, busy, timeout_err;
    logic [11:0] outs;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    assign outs = {mem_req, mem_we, ld_mar, ld_mdr, ld_ir, ld_pc,
                   mar_sel, mdr_sel, fetch_done, data_done, busy, timeout_err};

    always #5 clk = ~clk;

    mem_access_sequencer #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .data_req    (data_req),
        .data_we     (data_we),
        .mem_ack     (mem_ack),
        .err_clr     (err_clr),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ld_mar      (ld_mar),
        .ld_mdr      (ld_mdr),
        .ld_ir       (ld_ir),
        .ld_pc       (ld_pc),
        .mar_sel     (mar_sel),
        .mdr_sel     (mdr_sel),
        .fetch_done  (fetch_done),
        .data_done   (data_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_txn(input int kind, input int req_cycles, input logic we);
        exp_t e;
        e.kind       = kind;
        e.req_cycles = req_cycles;
        e.we         = we;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per completed transaction or timeout.
    initial begin : monitor
        int   req_cnt;
        logic we_seen;
        logic prev_terr;
        int   kind;
        exp_t e;
        req_cnt   = 0;
        we_seen   = 1'b0;
        prev_terr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_cnt   = 0;
                we_seen   = 1'b0;
                prev_terr = 1'b0;
            end else begin
                if (mem_req) begin
                    req_cnt++;
                    we_seen = we_seen | mem_we;
                end
                if (fetch_done || data_done || (timeout_err && !prev_terr)) begin
                    kind = fetch_done ? K_FETCH : (data_done ? K_DATA : K_ERR);
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected actual_kind=%0d required=none at %0t", kind, $time);
                    end else begin
                        e = sb.pop_front();
                        check("sb_kind", kind, e.kind);
                        check("sb_req_cycles", req_cnt, e.req_cycles);
                        check("sb_we", {31'b0, we_seen}, {31'b0, e.we});
                    end
                    req_cnt = 0;
                    we_seen = 1'b0;
                end
                prev_terr = timeout_err;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n_done;
        rst_n     = 1'b0;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        data_we   = 1'b0;
        mem_ack   = 1'b0;
        err_clr   = 1'b0;
        #2;
        check("reset_outs", outs, O_IDLE);
        #20 rst_n = 1'b1;
        tick();
        check("idle_after_reset", outs, O_IDLE);

        // Round-robin from reset with both requests held and ack always high
        fetch_req = 1'b1;
        data_req  = 1'b1;
        mem_ack   = 1'b1;
        expect_txn(K_FETCH, 1, 1'b0);
        expect_txn(K_DATA, 1, 1'b0);
        expect_txn(K_FETCH, 1, 1'b0);
        expect_txn(K_DATA, 1, 1'b0);
        tick();
        check("rr_first_tie_fetch", outs, O_F_ADDR);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (fetch_done || data_done) n_done++;
            if (n_done == 4) begin
                fetch_req = 1'b0;
                data_req  = 1'b0;
                mem_ack   = 1'b0;
                break;
            end
        end
        check("rr_done_count", n_done, 4);
        tick();
        tick();
        check("rr_back_idle", outs, O_IDLE);

        // Zero-wait fetch latency; early ack ignored outside the wait state
        fetch_req = 1'b1;
        mem_ack   = 1'b1;
        expect_txn(K_FETCH, 1, 1'b0);
        tick();
        check("fetch_addr_n1", outs, O_F_ADDR);
        tick();
        check("fetch_wait_n2", outs, O_F_WAIT_AK);
        tick();
        check("fetch_load_n3", outs, O_F_LOAD);
        fetch_req = 1'b0;
        mem_ack   = 1'b0;
        tick();
        check("fetch_idle", outs, O_IDLE);

        // Write with ack after three wait cycles; data_we dropped after grant
        data_req = 1'b1;
        data_we  = 1'b1;
        expect_txn(K_DATA, 4, 1'b1);
        tick();
        check("wr_addr", outs, O_D_ADDR_W);
        data_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wr_wait", outs, O_D_WAIT_W);
        end
        tick();
        mem_ack = 1'b1;
        #1;
        check("wr_wait_ack_no_ldmdr", outs, O_D_WAIT_W);
        tick();
        check("wr_done", outs, O_D_DONE);
        data_req = 1'b0;
        mem_ack  = 1'b0;
        tick();
        check("wr_idle", outs, O_IDLE);

        // Read acked on the last allowed wait cycle completes without error
        data_req = 1'b1;
        expect_txn(K_DATA, 4, 1'b0);
        tick();
        check("rd_addr", outs, O_D_ADDR_R);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_wait", outs, O_D_WAIT_R);
        end
        tick();
        mem_ack = 1'b1;
        #1;
        check("rd_wait_ack_boundary", outs, O_D_WAIT_RA);
        tick();
        check("rd_done_no_err", outs, O_D_DONE);
        data_req = 1'b0;
        mem_ack  = 1'b0;
        tick();
        check("rd_idle", outs, O_IDLE);

        // Fetch timeout: four wait cycles, ERR, sticky flag, then clear
        fetch_req = 1'b1;
        expect_txn(K_ERR, 4, 1'b0);
        tick();
        check("to_addr", outs, O_F_ADDR);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_wait", outs, O_F_WAIT);
        end
        tick();
        check("to_err_state", outs, O_ERR);
        fetch_req = 1'b0;
        tick();
        check("to_err_sticky_idle", outs, O_IDLE_ERR);
        tick();
        check("to_err_sticky_hold", outs, O_IDLE_ERR);
        err_clr = 1'b1;
        tick();
        check("to_err_cleared", outs, O_IDLE);
        err_clr = 1'b0;

        // Asynchronous reset during a data wait aborts it silently
        data_req = 1'b1;
        tick();
        check("rst_addr", outs, O_D_ADDR_R);
        tick();
        check("rst_wait", outs, O_D_WAIT_R);
        #2;
        rst_n    = 1'b0;
        data_req = 1'b0;
        #1;
        check("rst_async_outs", outs, O_IDLE);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        fetch_req = 1'b1;
        mem_ack   = 1'b1;
        expect_txn(K_FETCH, 1, 1'b0);
        tick();
        check("post_rst_addr", outs, O_F_ADDR);
        tick();
        check("post_rst_wait", outs, O_F_WAIT_AK);
        tick();
        check("post_rst_load", outs, O_F_LOAD);
        fetch_req = 1'b0;
        mem_ack   = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", outs, O_IDLE);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max wait cycles for mem_ack; 0 disables the timeout.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports fetch_req  in  1 and data_req  in  1: level requests, held until the matching done pulse.
REQ-005 SHALL have port data_we  in  1  write qualifier for data_req, captured at grant.
REQ-006 SHALL have port mem_ack  in  1  memory completion, sampled only in wait states.
REQ-007 SHALL have ports mem_req  out  1 and mem_we  out  1: memory handshake.
REQ-008 SHALL have ports ld_mar, ld_mdr, ld_ir, ld_pc  out  1 each: load enables of the corresponding program registers.
REQ-009 SHALL have port mar_sel  out  1: 0 = PC, 1 = data address.
REQ-010 SHALL have port mdr_sel  out  1: 0 = memory read data, 1 = store data.
REQ-011 SHALL have ports fetch_done  out  1 and data_done  out  1: single-cycle completion pulses.
REQ-012 SHALL have ports busy  out  1 (state != IDLE), timeout_err  out  1 (sticky), and err_clr  in  1.

Function
REQ-013 SHALL implement states IDLE, F_ADDR, F_WAIT, F_LOAD, D_ADDR, D_WAIT, D_DONE, ERR.
REQ-014 IDLE, only fetch_req: next F_ADDR; only data_req: next D_ADDR; neither: stay.
REQ-015 IDLE, both requests: grant the requester not granted last (round-robin); the last-grant flag resets to "data", so fetch wins the first tie.
REQ-016 F_ADDR: ld_mar=1, mar_sel=0, one cycle; next F_WAIT.
REQ-017 F_WAIT: mem_req=1, mem_we=0; when mem_ack=1, same cycle ld_mdr=1, mdr_sel=0, next F_LOAD.
REQ-018 F_LOAD: ld_ir=1, ld_pc=1, fetch_done=1, one cycle; next IDLE.
REQ-019 D_ADDR: ld_mar=1, mar_sel=1; if the captured write flag is set, also ld_mdr=1, mdr_sel=1; next D_WAIT.
REQ-020 D_WAIT: mem_req=1, mem_we=captured write flag; on mem_ack, a read asserts ld_mdr=1, mdr_sel=0 same cycle; next D_DONE.
REQ-021 D_DONE: data_done=1, one cycle; next IDLE.
REQ-022 All outputs other than the ack-qualified ld_mdr/mdr_sel SHALL be decoded from state only (Moore).
REQ-023 Unlisted load enables and selects SHALL be 0 in every state.
REQ-024 Wait counter SHALL clear on entry to F_WAIT/D_WAIT and increment each wait cycle without ack.
REQ-025 TIMEOUT>0 and counter == TIMEOUT-1 with mem_ack=0: next ERR and set timeout_err; mem_ack in the same cycle takes priority over timeout.
REQ-026 ERR: all outputs 0 except busy and timeout_err, no done pulse; next IDLE.
REQ-027 timeout_err SHALL clear on err_clr=1 unless it is being set in the same cycle (set wins).
REQ-028 mem_ack outside wait states SHALL be ignored.
REQ-029 Requests dropped after grant SHALL NOT abort the sequence.
REQ-030 Fetch latency with zero-wait ack: grant in IDLE cycle N, fetch_done in cycle N+3.

Reset
REQ-031 rst_n low SHALL force IDLE, counter 0, last-grant = data, timeout_err 0, captured write flag 0 and all outputs 0 immediately, independent of clk.
REQ-032 Reset asserted mid-sequence SHALL abort it with no done pulse; operation resumes from IDLE on the first edge after release.

Structure
REQ-033 The state enum and the default TIMEOUT constant SHALL live in shared package seq_pkg.
REQ-034 The wait counter SHALL be sub-module wait_timer (clear, enable, expiry output), sized $clog2(TIMEOUT+1), min 1 bit.

Verification
REQ-035 fetch_req=1, mem_ack high on the first F_WAIT cycle -> ld_mar at N+1, mem_req and ld_mdr at N+2, ld_ir/ld_pc/fetch_done at N+3.
REQ-036 data_req=1, data_we=1, ack after 3 wait cycles -> D_ADDR ld_mar=1, ld_mdr=1, mdr_sel=1; mem_we=1 for 4 cycles; data_done 1 cycle after ack; no ld_mdr on ack.
REQ-037 Both requests held continuously, ack immediate -> grants alternate fetch, data, fetch, data from reset.
REQ-038 TIMEOUT=4, no ack -> 4 wait cycles, then ERR, timeout_err=1 and stays set; err_clr=1 -> 0 next cycle; no done pulse.
REQ-039 mem_ack on exactly the 4th wait cycle (TIMEOUT=4) -> normal completion, timeout_err stays 0.
REQ-040 rst_n low during D_WAIT -> mem_req falls without a clock edge, no data_done; after release, a new fetch completes normally.
